clk_gen: RTL and testbench

Parametrised multi-channel clock divider and tick generator driven by the board clock. Each channel divides `clk_board` by a run-time programmable ratio and provides both a divided square wave and single-cycle enable pulses for synchronous consumers. Channel 0 is the CPU clock and can optionally be frozen and single-stepped for debug. The block sits at the top level between the board oscillator and the CPU, LED and display logic.

---
 rtl/clkgen_pkg.sv | 15 +
 rtl/clkgen_chan.sv | 59 +++++
 rtl/clk_gen.sv | 122 ++++++++++++
 tb/tb_clk_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared types and default divisor constants for the clk_gen clock divider.
package clkgen_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2,
    STEP  = 2'd3
  } step_state_t;

  localparam int          CNT_W_DEFAULT   = 32;
  localparam logic [31:0] CPU_DIV_DEFAULT = 32'd4999999;
  localparam logic [31:0] LED_DIV_DEFAULT = 32'd49999;

endpackage

// File: rtl/clkgen_chan.sv
// One divider channel: counter, active/pending terminal count, toggle and tick pulses.
// Outputs are registered; freeze holds the counter, clr forces it to zero.
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] TC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             freeze,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             at_tc,
  output logic             clk_out,
  output logic             tick,
  output logic             rise
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tc;
  logic [CNT_W-1:0] tc_pend;
  logic             active;
  logic             wrap;

  // >= rather than == so a shrunken tc still wraps instead of running to overflow
  assign at_tc  = (cnt >= tc);
  assign active = en && !freeze;
  assign wrap   = active && at_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tc      <= TC_INIT;
      tc_pend <= TC_INIT;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      rise    <= 1'b0;
    end else begin
      tick <= wrap;
      rise <= wrap && !clk_out;
      if (wr) begin
        tc_pend <= wr_val;
      end
      if (wrap) begin
        tc      <= wr ? wr_val : tc_pend;
        clk_out <= !clk_out;
      end
      if (clr || wrap) begin
        cnt <= '0;
      end else if (active) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_gen.sv
// Multi-channel clock divider / tick generator; all outputs registered on clk_board.
// Channel 0 freeze/single-step FSM is built only when CLKGEN_STEP_EN is defined.
module clk_gen
  import clkgen_pkg::*;
#(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = CNT_W_DEFAULT,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {LED_DIV_DEFAULT, CPU_DIV_DEFAULT},
  localparam int                     SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_board,
  input  logic              rst_n,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              step_mode,
  input  logic              step_req,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] rise,
  output logic              step_ack,
  output logic              halted
);

  logic [NUM_CH-1:0] at_tc;
  logic [NUM_CH-1:0] freeze;
  logic [NUM_CH-1:0] clr;
  logic              freeze0;
  logic              clr0;
  logic              unused_sig;

  assign unused_sig = ^{at_tc, step_mode, step_req};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_i;

    assign wr_i      = div_wr && (int'(div_sel) == i);
    assign freeze[i] = (i == 0) ? freeze0 : 1'b0;
    assign clr[i]    = (i == 0) ? clr0 : 1'b0;

    clkgen_chan #(
      .CNT_W   (CNT_W),
      .TC_INIT (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk     (clk_board),
      .rst_n   (rst_n),
      .en      (ch_en[i]),
      .freeze  (freeze[i]),
      .clr     (clr[i]),
      .wr      (wr_i),
      .wr_val  (div_val),
      .at_tc   (at_tc[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .rise    (rise[i])
    );
  end

`ifdef CLKGEN_STEP_EN
  step_state_t state;
  step_state_t state_nxt;
  logic        ack_nxt;

  always_ff @(posedge clk_board or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      step_ack <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_ack <= ack_nxt;
      halted   <= (state_nxt == HALT);
    end
  end

  always_comb begin
    state_nxt = state;
    freeze0   = 1'b0;
    clr0      = 1'b0;
    ack_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (ch_en[0] && step_mode) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Already low: park immediately, discarding the partial count.
        if (!clk_out[0]) begin
          freeze0 = 1'b1;
          if (ch_en[0]) begin
            clr0      = 1'b1;
            state_nxt = HALT;
          end
        end else if (ch_en[0] && at_tc[0]) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        freeze0 = 1'b1;
        if (ch_en[0]) begin
          if (!step_mode)    state_nxt = RUN;
          else if (step_req) state_nxt = STEP;
        end
      end
      STEP: begin
        // Falling toggle ends the step.
        if (ch_en[0] && clk_out[0] && at_tc[0]) begin
          state_nxt = step_mode ? HALT : RUN;
          ack_nxt   = step_mode;
        end
      end
      default: state_nxt = RUN;
    endcase
  end
`else
  assign freeze0  = 1'b0;
  assign clr0     = 1'b0;
  assign step_ack = 1'b0;
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_clk_gen.sv
// Directed, table-driven bench for clk_gen (ch0 T=3, ch1 T=1 at reset, 8-bit counters).
module tb_clk_gen;

  logic       clk_board = 1'b0;
  logic       rst_n;
  logic       div_wr;
  logic       div_sel;
  logic [7:0] div_val;
  logic [1:0] ch_en;
  logic       step_mode;
  logic       step_req;
  logic [1:0] clk_out;
  logic [1:0] tick;
  logic [1:0] rise;
  logic       step_ack;
  logic       halted;

  int n_vec = 0;
  int n_err = 0;

  clk_gen #(
    .NUM_CH   (2),
    .CNT_W    (8),
    .DIV_INIT ({8'd1, 8'd3})
  ) dut (
    .clk_board (clk_board),
    .rst_n     (rst_n),
    .div_wr    (div_wr),
    .div_sel   (div_sel),
    .div_val   (div_val),
    .ch_en     (ch_en),
    .step_mode (step_mode),
    .step_req  (step_req),
    .clk_out   (clk_out),
    .tick      (tick),
    .rise      (rise),
    .step_ack  (step_ack),
    .halted    (halted)
  );

  always #5 clk_board = ~clk_board;

  typedef struct {
    logic [1:0] en;
    logic       wr;
    logic [7:0] val;
    logic [1:0] clk;
    logic [1:0] tk;
    logic [1:0] rs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] en, logic wr, logic [7:0] val,
                              logic [1:0] c, logic [1:0] t, logic [1:0] r);
    vec_t v;
    v.en = en; v.wr = wr; v.val = val; v.clk = c; v.tk = t; v.rs = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_board);
    #1;
  endtask

  logic [2:0] step_exp[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ch_en = 2'b11; div_wr = 1'b0; div_sel = 1'b0; div_val = 8'd0;
    step_mode = 1'b0; step_req = 1'b0;

    // Edges 1..37 after reset release: {ch_en, wr, val, clk_out, tick, rise}
    tbl.push_back(mk(2'b11,0,0, 2'b00,2'b00,2'b00)); // 1
    tbl.push_back(mk(2'b11,0,0, 2'b10,2'b10,2'b10)); // 2
    tbl.push_back(mk(2'b11,0,0, 2'b10,2'b00,2'b00)); // 3
    tbl.push_back(mk(2'b11,0,0, 2'b01,2'b11,2'b01)); // 4
    tbl.push_back(mk(2'b11,0,0, 2'b01,2'b00,2'b00)); // 5
    tbl.push_back(mk(2'b11,0,0, 2'b11,2'b10,2'b10)); // 6
    tbl.push_back(mk(2'b11,0,0, 2'b11,2'b00,2'b00)); // 7
    tbl.push_back(mk(2'b11,0,0, 2'b00,2'b11,2'b00)); // 8
    tbl.push_back(mk(2'b11,0,0, 2'b00,2'b00,2'b00)); // 9
    tbl.push_back(mk(2'b11,0,0, 2'b10,2'b10,2'b10)); // 10
    tbl.push_back(mk(2'b11,0,0, 2'b10,2'b00,2'b00)); // 11
    tbl.push_back(mk(2'b11,0,0, 2'b01,2'b11,2'b01)); // 12
    tbl.push_back(mk(2'b11,0,0, 2'b01,2'b00,2'b00)); // 13
    tbl.push_back(mk(2'b11,0,0, 2'b11,2'b10,2'b10)); // 14
    tbl.push_back(mk(2'b11,0,0, 2'b11,2'b00,2'b00)); // 15
    tbl.push_back(mk(2'b11,0,0, 2'b00,2'b11,2'b00)); // 16
    tbl.push_back(mk(2'b11,0,0, 2'b00,2'b00,2'b00)); // 17 ch0 cnt=1
    tbl.push_back(mk(2'b11,1,0, 2'b10,2'b10,2'b10)); // 18 write T=0 mid half-period
    tbl.push_back(mk(2'b11,0,0, 2'b10,2'b00,2'b00)); // 19
    tbl.push_back(mk(2'b11,0,0, 2'b01,2'b11,2'b01)); // 20 old half-period completes
    tbl.push_back(mk(2'b11,0,0, 2'b00,2'b01,2'b00)); // 21
    tbl.push_back(mk(2'b11,0,0, 2'b11,2'b11,2'b11)); // 22
    tbl.push_back(mk(2'b11,0,0, 2'b10,2'b01,2'b00)); // 23
    tbl.push_back(mk(2'b11,0,0, 2'b01,2'b11,2'b01)); // 24
    tbl.push_back(mk(2'b11,1,2, 2'b00,2'b01,2'b00)); // 25 write T=2 on a wrap
    tbl.push_back(mk(2'b11,0,0, 2'b10,2'b10,2'b10)); // 26
    tbl.push_back(mk(2'b11,0,0, 2'b10,2'b00,2'b00)); // 27
    tbl.push_back(mk(2'b11,0,0, 2'b01,2'b11,2'b01)); // 28
    tbl.push_back(mk(2'b11,0,0, 2'b01,2'b00,2'b00)); // 29 ch1 cnt=1
    tbl.push_back(mk(2'b01,0,0, 2'b01,2'b00,2'b00)); // 30 ch1 disabled x5
    tbl.push_back(mk(2'b01,0,0, 2'b00,2'b01,2'b00)); // 31
    tbl.push_back(mk(2'b01,0,0, 2'b00,2'b00,2'b00)); // 32
    tbl.push_back(mk(2'b01,0,0, 2'b00,2'b00,2'b00)); // 33
    tbl.push_back(mk(2'b01,0,0, 2'b01,2'b01,2'b01)); // 34
    tbl.push_back(mk(2'b11,0,0, 2'b11,2'b10,2'b10)); // 35 ch1 rise 5 edges late
    tbl.push_back(mk(2'b11,0,0, 2'b11,2'b00,2'b00)); // 36
    tbl.push_back(mk(2'b11,0,0, 2'b00,2'b11,2'b00)); // 37

    // {clk_out[0], step_ack, halted} for edges k=0..9 after the first step_req
    step_exp[0] = 3'b000; step_exp[1] = 3'b000; step_exp[2] = 3'b000;
    step_exp[3] = 3'b100; step_exp[4] = 3'b100; step_exp[5] = 3'b100;
    step_exp[6] = 3'b011; step_exp[7] = 3'b001; step_exp[8] = 3'b001;
    step_exp[9] = 3'b001;

    repeat (2) cyc();
    chk("reset", {clk_out, tick, rise, step_ack, halted}, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      ch_en   = tbl[i].en;
      div_wr  = tbl[i].wr;
      div_val = tbl[i].val;
      cyc();
      chk($sformatf("vec%0d", i + 1), {clk_out, tick, rise, step_ack, halted},
          {tbl[i].clk, tbl[i].tk, tbl[i].rs, 2'b00});
    end
    ch_en = 2'b11; div_wr = 1'b0; div_val = 8'd0;

`ifdef CLKGEN_STEP_EN
    for (int i = 0; i < 8 && !clk_out[0]; i++) cyc();
    chk("pre_drain_high", {7'd0, clk_out[0]}, 8'd1);
    step_mode = 1'b1;
    for (int i = 0; i < 3 && !halted; i++) cyc();
    chk("drain_halt", {6'd0, halted, clk_out[0]}, 8'b10);
    repeat (3) cyc();
    chk("halt_hold", {5'd0, halted, clk_out[0], tick[0]}, 8'b100);

    for (int k = 0; k < 10; k++) begin
      step_req = (k < 2);
      cyc();
      chk($sformatf("step_k%0d", k), {5'd0, clk_out[0], step_ack, halted}, {5'd0, step_exp[k]});
    end
    step_req = 1'b0;

    step_mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("release_k%0d", k), {5'd0, clk_out[0], rise[0], halted},
          (k == 3) ? 8'b110 : 8'b000);
    end

    step_mode = 1'b1;
    for (int i = 0; i < 8 && !halted; i++) cyc();
    chk("rehalt", {7'd0, halted}, 8'd1);
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    repeat (3) cyc();
    chk("step_high", {6'd0, clk_out[0], halted}, 8'b10);
`else
    for (int k = 1; k <= 6; k++) begin
      step_mode = 1'b1;
      step_req  = k[0];
      cyc();
      chk($sformatf("nostep_k%0d", k), {5'd0, clk_out[0], step_ack, halted},
          (k >= 3 && k <= 5) ? 8'b100 : 8'b000);
    end
    step_req = 1'b0;
    for (int i = 0; i < 8 && !clk_out[0]; i++) cyc();
    chk("pre_reset_high", {7'd0, clk_out[0]}, 8'd1);
`endif

    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {clk_out, tick, rise, step_ack, halted}, 8'h00);
    step_mode = 1'b0;
    step_req  = 1'b0;
    repeat (2) cyc();
    chk("reset_hold", {clk_out, tick, rise, step_ack, halted}, 8'h00);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("post_reset_e%0d", k), {4'd0, clk_out[0], tick[0], step_ack, halted},
          (k == 4) ? 8'b1100 : 8'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
